// File: rtl/id_pkg.sv
// Shared definitions for the decode/dispatch stage: opcode map, decoded
// control bundle layout and the dispatch FSM state encoding.
package id_pkg;

  localparam logic [5:0] OP_ALU    = 6'h01;
  localparam logic [5:0] OP_ADDI   = 6'h02;
  localparam logic [5:0] OP_LD     = 6'h03;
  localparam logic [5:0] OP_ST     = 6'h04;
  localparam logic [5:0] OP_BEQ    = 6'h05;
  localparam logic [5:0] OP_J      = 6'h06;
  localparam logic [5:0] OP_JAL    = 6'h07;
  localparam logic [5:0] OP_JR     = 6'h08;
  localparam logic [5:0] OP_LDI    = 6'h09;
  localparam logic [5:0] OP_STRCNT = 6'h10;
  localparam logic [5:0] OP_STPCNT = 6'h11;
  localparam logic [5:0] OP_HALT   = 6'h3F;

  typedef struct packed {
    logic       writeRd;
    logic       MemOp;
    logic       RegDest;
    logic       RS_en;
    logic       ldic;
    logic       isSignEx;
    logic       immed;
    logic [3:0] alu_ctrl;
    logic       isJump;
    logic       isJR;
    logic       ld;
    logic       mem_wen;
    logic       link;
    logic       strcnt;
    logic       stpcnt;
    logic       halt;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

endpackage

// File: rtl/id_decoder.sv
// Combinational opcode decoder producing one control bundle per instruction.
// Any opcode not in the map yields an all-zero bundle, which the dispatch
// stage treats as a NOP needing only a ROB entry.
module id_decoder
  import id_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  // Map each known opcode to its control bits; everything else stays zero.
  always_comb begin
    ctrl = '0;
    unique case (opcode)
      OP_ALU: begin
        ctrl.writeRd = 1'b1; ctrl.RegDest = 1'b1; ctrl.RS_en = 1'b1;
        ctrl.alu_ctrl = 4'h1;
      end
      OP_ADDI: begin
        ctrl.writeRd = 1'b1; ctrl.RegDest = 1'b1; ctrl.RS_en = 1'b1;
        ctrl.isSignEx = 1'b1; ctrl.immed = 1'b1; ctrl.alu_ctrl = 4'h1;
      end
      OP_LD: begin
        ctrl.writeRd = 1'b1; ctrl.RegDest = 1'b1; ctrl.RS_en = 1'b1;
        ctrl.MemOp = 1'b1; ctrl.ld = 1'b1; ctrl.isSignEx = 1'b1; ctrl.immed = 1'b1;
      end
      OP_ST: begin
        ctrl.RS_en = 1'b1; ctrl.MemOp = 1'b1; ctrl.mem_wen = 1'b1;
        ctrl.isSignEx = 1'b1; ctrl.immed = 1'b1;
      end
      OP_BEQ: begin
        ctrl.RS_en = 1'b1; ctrl.isSignEx = 1'b1; ctrl.immed = 1'b1;
        ctrl.alu_ctrl = 4'h2;
      end
      OP_J:   ctrl.isJump = 1'b1;
      OP_JAL: begin
        ctrl.isJump = 1'b1; ctrl.link = 1'b1; ctrl.writeRd = 1'b1; ctrl.RegDest = 1'b1;
      end
      OP_JR: begin
        ctrl.isJR = 1'b1; ctrl.RS_en = 1'b1;
      end
      OP_LDI: begin
        ctrl.writeRd = 1'b1; ctrl.RegDest = 1'b1; ctrl.ldic = 1'b1; ctrl.immed = 1'b1;
      end
      OP_STRCNT: ctrl.strcnt = 1'b1;
      OP_STPCNT: ctrl.stpcnt = 1'b1;
      OP_HALT:   ctrl.halt = 1'b1;
      default:   ctrl = '0;
    endcase
  end

endmodule

// File: rtl/id_dispatch_wide.sv
// N-wide in-order decode/dispatch stage. Fetched groups land in a circular
// decode queue; up to WIDTH head entries are decoded and dispatched per cycle,
// limited by RS/ROB/free-list capacity, recovery flush, arbiter stall and halt.
// Optional macro ID_PERF_CNT_EN adds saturating stall-cause counters.
module id_dispatch_wide
  import id_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int IQ_DEPTH = 8,
  parameter int INSTR_W  = 32,
  parameter int CNT_W    = 6
)
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           fetch_valid,
  input  logic [WIDTH*INSTR_W-1:0]   fetch_instr,
  output logic                       fetch_ready,
  input  logic [CNT_W-1:0]           rs_free,
  input  logic [CNT_W-1:0]           rob_free,
  input  logic [CNT_W-1:0]           fl_free,
  input  logic                       stall_recover,
  input  logic                       stall_arbiter,
  output logic [WIDTH-1:0]           dsp_valid,
  output logic [WIDTH*INSTR_W-1:0]   dsp_instr,
  output logic [WIDTH*CTRL_W-1:0]    dsp_ctrl,
  output logic                       halted
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0]                perf_rs_stall,
  output logic [31:0]                perf_rob_stall,
  output logic [31:0]                perf_fl_stall,
  output logic [31:0]                perf_arb_stall
`endif
);

  localparam int PTR_W  = $clog2(IQ_DEPTH);
  localparam int QCNT_W = PTR_W + 1;
  localparam int SUM_W  = CNT_W + 1;

  state_t             state;
  logic [PTR_W-1:0]   head, tail;
  logic [QCNT_W-1:0]  count, push_cnt, pop_cnt;
  logic [INSTR_W-1:0] queue [IQ_DEPTH];
  logic [INSTR_W-1:0] head_instr [WIDTH];
  ctrl_t              head_ctrl [WIDTH];
  logic [WIDTH-1:0]   push_mask;
  logic [SUM_W-1:0]   rob_sum, rs_sum, fl_sum;
  logic               dispatch_en, chain, lane_ok, halt_dispatched, push_chain;

  assign dispatch_en = !rst && (state == RUN) && !stall_recover && !stall_arbiter;
  assign fetch_ready = (state == RUN) && !stall_recover &&
                       ((QCNT_W'(IQ_DEPTH) - count) >= QCNT_W'(WIDTH));
  assign halted      = (state == HALTED);

  // Read the WIDTH entries starting at the head; pointer arithmetic wraps naturally.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      head_instr[i] = queue[head + PTR_W'(i)];
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_dec
    id_decoder u_dec (
      .opcode (head_instr[g][INSTR_W-1 -: 6]),
      .ctrl   (head_ctrl[g])
    );
  end

  // Only the contiguous valid prefix of a fetch group is enqueued, and only when ready.
  always_comb begin
    push_mask  = '0;
    push_cnt   = '0;
    push_chain = fetch_ready;
    for (int k = 0; k < WIDTH; k++) begin
      push_chain   = push_chain && fetch_valid[k];
      push_mask[k] = push_chain;
      push_cnt     = push_cnt + QCNT_W'(push_chain);
    end
  end

  // Grow the dispatch group lane by lane until occupancy, resources or a halt stop it.
  always_comb begin
    dsp_valid       = '0;
    rob_sum         = '0;
    rs_sum          = '0;
    fl_sum          = '0;
    pop_cnt         = '0;
    halt_dispatched = 1'b0;
    lane_ok         = 1'b0;
    chain           = dispatch_en;
    for (int i = 0; i < WIDTH; i++) begin
      rob_sum = rob_sum + SUM_W'(1);
      rs_sum  = rs_sum + SUM_W'(head_ctrl[i].RS_en);
      fl_sum  = fl_sum + SUM_W'(head_ctrl[i].RegDest);
      lane_ok = chain && (QCNT_W'(i) < count) &&
                (rob_sum <= {1'b0, rob_free}) &&
                (rs_sum  <= {1'b0, rs_free}) &&
                (fl_sum  <= {1'b0, fl_free});
      dsp_valid[i]    = lane_ok;
      pop_cnt         = pop_cnt + QCNT_W'(lane_ok);
      halt_dispatched = halt_dispatched || (lane_ok && head_ctrl[i].halt);
      chain           = lane_ok && !head_ctrl[i].halt;
    end
  end

  // Flatten the per-lane head entries and bundles onto the dispatch buses.
  always_comb begin
    dsp_instr = '0;
    dsp_ctrl  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dsp_instr[i*INSTR_W +: INSTR_W] = head_instr[i];
      dsp_ctrl[i*CTRL_W +: CTRL_W]    = head_ctrl[i];
    end
  end

  // Queue storage: accepted lanes are written at the tail in lane order.
  always_ff @(posedge clk) begin
    for (int k = 0; k < WIDTH; k++) begin
      if (!rst && push_mask[k]) begin
        queue[tail + PTR_W'(k)] <= fetch_instr[k*INSTR_W +: INSTR_W];
      end
    end
  end

  // Dispatch FSM plus queue pointers; recovery clears the queue, halt is sticky until rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (stall_recover) begin
            state <= FLUSH;
            head  <= '0;
            tail  <= '0;
            count <= '0;
          end else begin
            if (halt_dispatched) state <= HALTED;
            head  <= head + PTR_W'(pop_cnt);
            tail  <= tail + PTR_W'(push_cnt);
            count <= count + push_cnt - pop_cnt;
          end
        end
        FLUSH: begin
          if (!stall_recover) state <= RUN;
          head  <= '0;
          tail  <= '0;
          count <= '0;
        end
        HALTED: state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

`ifdef ID_PERF_CNT_EN
  logic perf_active, rs_block, rob_block, fl_block;

  assign perf_active = (state == RUN) && !stall_recover && (count != '0);
  assign rs_block    = head_ctrl[0].RS_en && (rs_free == '0);
  assign rob_block   = (rob_free == '0);
  assign fl_block    = head_ctrl[0].RegDest && (fl_free == '0);

  // Saturating per-cause stall counters; HALTED is never RUN, so they freeze there.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rs_stall  <= '0;
      perf_rob_stall <= '0;
      perf_fl_stall  <= '0;
      perf_arb_stall <= '0;
    end else if (perf_active) begin
      if (rs_block && (perf_rs_stall != '1))        perf_rs_stall  <= perf_rs_stall + 32'd1;
      if (rob_block && (perf_rob_stall != '1))      perf_rob_stall <= perf_rob_stall + 32'd1;
      if (fl_block && (perf_fl_stall != '1))        perf_fl_stall  <= perf_fl_stall + 32'd1;
      if (stall_arbiter && (perf_arb_stall != '1))  perf_arb_stall <= perf_arb_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_dispatch_wide.sv
// Directed, table-driven bench for id_dispatch_wide at WIDTH=2, IQ_DEPTH=8.
// Each row drives one cycle of inputs and lists the hand-computed outputs
// expected in that same cycle.
module tb_id_dispatch_wide;

  localparam int WIDTH   = 2;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 6;
  localparam int CTRL_W  = id_pkg::CTRL_W;

  localparam logic [5:0] T_ALU  = 6'h01;
  localparam logic [5:0] T_ST   = 6'h04;
  localparam logic [5:0] T_UNK  = 6'h2A;
  localparam logic [5:0] T_HALT = 6'h3F;

  typedef struct {
    logic [1:0]  fv;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [5:0]  rs;
    logic [5:0]  rob;
    logic [5:0]  fl;
    logic        rec;
    logic        arb;
    logic [1:0]  exp_v;
    logic        exp_rdy;
    logic        exp_halt;
    logic [31:0] exp_i0;
    logic [31:0] exp_i1;
    logic        zero_ctrl;
  } vec_t;

  logic                     clk;
  logic                     rst;
  logic [WIDTH-1:0]         fetch_valid;
  logic [WIDTH*INSTR_W-1:0] fetch_instr;
  logic                     fetch_ready;
  logic [CNT_W-1:0]         rs_free, rob_free, fl_free;
  logic                     stall_recover, stall_arbiter;
  logic [WIDTH-1:0]         dsp_valid;
  logic [WIDTH*INSTR_W-1:0] dsp_instr;
  logic [WIDTH*CTRL_W-1:0]  dsp_ctrl;
  logic                     halted;

  int checks   = 0;
  int failures = 0;

  vec_t tbl[$];
  vec_t seq_rec[$];
  vec_t seq_halt[$];
  vec_t seq_halt1[$];

  id_dispatch_wide #(.WIDTH(WIDTH), .IQ_DEPTH(8), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_valid   (fetch_valid),
    .fetch_instr   (fetch_instr),
    .fetch_ready   (fetch_ready),
    .rs_free       (rs_free),
    .rob_free      (rob_free),
    .fl_free       (fl_free),
    .stall_recover (stall_recover),
    .stall_arbiter (stall_arbiter),
    .dsp_valid     (dsp_valid),
    .dsp_instr     (dsp_instr),
    .dsp_ctrl      (dsp_ctrl),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] op, input int tag);
    return {op, 26'(tag)};
  endfunction

  function automatic vec_t mkv(input logic [1:0] fv, input logic [31:0] i0, input logic [31:0] i1,
                               input int rs, input int rob, input int fl, input logic rec,
                               input logic arb, input logic [1:0] ev, input logic erdy,
                               input logic ehalt, input logic [31:0] ei0, input logic [31:0] ei1,
                               input logic zc);
    vec_t v;
    v.fv = fv; v.i0 = i0; v.i1 = i1;
    v.rs = 6'(rs); v.rob = 6'(rob); v.fl = 6'(fl);
    v.rec = rec; v.arb = arb;
    v.exp_v = ev; v.exp_rdy = erdy; v.exp_halt = ehalt;
    v.exp_i0 = ei0; v.exp_i1 = ei1; v.zero_ctrl = zc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    fetch_valid   = v.fv;
    fetch_instr   = {v.i1, v.i0};
    rs_free       = v.rs;
    rob_free      = v.rob;
    fl_free       = v.fl;
    stall_recover = v.rec;
    stall_arbiter = v.arb;
  endtask

  task automatic runRow(input string tag, input vec_t v);
    @(posedge clk);
    #1;
    applyStimulus(v);
    @(negedge clk);
    checkOutput({tag, " dsp_valid"}, 64'(dsp_valid), 64'(v.exp_v));
    checkOutput({tag, " fetch_ready"}, 64'(fetch_ready), 64'(v.exp_rdy));
    checkOutput({tag, " halted"}, 64'(halted), 64'(v.exp_halt));
    if (v.exp_v[0]) checkOutput({tag, " instr0"}, 64'(dsp_instr[31:0]), 64'(v.exp_i0));
    if (v.exp_v[1]) checkOutput({tag, " instr1"}, 64'(dsp_instr[63:32]), 64'(v.exp_i1));
    if (v.zero_ctrl) checkOutput({tag, " ctrl0"}, 64'(dsp_ctrl[CTRL_W-1:0]), 64'd0);
  endtask

  task automatic doReset(input string tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(mkv(2'b00, 0, 0, 10, 10, 10, 0, 0, 2'b00, 1, 0, 0, 0, 0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput({tag, " dsp_valid"}, 64'(dsp_valid), 64'd0);
    checkOutput({tag, " fetch_ready"}, 64'(fetch_ready), 64'd1);
    checkOutput({tag, " halted"}, 64'(halted), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(mkv(2'b00, 0, 0, 10, 10, 10, 0, 0, 2'b00, 1, 0, 0, 0, 0));

    // Steady dispatch, per-resource limits, full queue and arbiter stall.
    tbl.push_back(mkv(2'b11, mk(T_ALU,0), mk(T_ALU,1), 10,10,10, 0,0, 2'b00,1,0, 0,0,0));
    tbl.push_back(mkv(2'b11, mk(T_ALU,2), mk(T_ALU,3), 10,10,10, 0,0, 2'b11,1,0, mk(T_ALU,0),mk(T_ALU,1),0));
    tbl.push_back(mkv(2'b00, 0,0, 10,10,10, 0,0, 2'b11,1,0, mk(T_ALU,2),mk(T_ALU,3),0));
    tbl.push_back(mkv(2'b00, 0,0, 10,10,10, 0,0, 2'b00,1,0, 0,0,0));
    tbl.push_back(mkv(2'b11, mk(T_ALU,4), mk(T_ALU,5), 10,10,10, 0,0, 2'b00,1,0, 0,0,0));
    tbl.push_back(mkv(2'b00, 0,0, 10,10,1, 0,0, 2'b01,1,0, mk(T_ALU,4),0,0));
    tbl.push_back(mkv(2'b00, 0,0, 10,10,1, 0,0, 2'b01,1,0, mk(T_ALU,5),0,0));
    tbl.push_back(mkv(2'b11, mk(T_ST,6), mk(T_ALU,7), 10,10,10, 0,0, 2'b00,1,0, 0,0,0));
    tbl.push_back(mkv(2'b00, 0,0, 10,10,0, 0,0, 2'b01,1,0, mk(T_ST,6),0,0));
    tbl.push_back(mkv(2'b00, 0,0, 0,10,10, 0,0, 2'b00,1,0, 0,0,0));
    tbl.push_back(mkv(2'b00, 0,0, 10,10,10, 0,0, 2'b01,1,0, mk(T_ALU,7),0,0));
    tbl.push_back(mkv(2'b11, mk(T_UNK,8), mk(T_ALU,9), 10,10,10, 0,0, 2'b00,1,0, 0,0,0));
    tbl.push_back(mkv(2'b00, 0,0, 0,10,0, 0,0, 2'b01,1,0, mk(T_UNK,8),0,1));
    tbl.push_back(mkv(2'b00, 0,0, 10,10,10, 0,0, 2'b01,1,0, mk(T_ALU,9),0,0));
    tbl.push_back(mkv(2'b11, mk(T_ALU,'h20), mk(T_ALU,'h21), 10,0,10, 0,0, 2'b00,1,0, 0,0,0));
    tbl.push_back(mkv(2'b11, mk(T_ALU,'h22), mk(T_ALU,'h23), 10,0,10, 0,0, 2'b00,1,0, 0,0,0));
    tbl.push_back(mkv(2'b11, mk(T_ALU,'h24), mk(T_ALU,'h25), 10,0,10, 0,0, 2'b00,1,0, 0,0,0));
    tbl.push_back(mkv(2'b11, mk(T_ALU,'h26), mk(T_ALU,'h27), 10,0,10, 0,0, 2'b00,1,0, 0,0,0));
    tbl.push_back(mkv(2'b11, mk(T_ALU,'h2E), mk(T_ALU,'h2F), 10,0,10, 0,0, 2'b00,0,0, 0,0,0));
    tbl.push_back(mkv(2'b00, 0,0, 10,2,10, 0,0, 2'b11,0,0, mk(T_ALU,'h20),mk(T_ALU,'h21),0));
    tbl.push_back(mkv(2'b00, 0,0, 10,0,10, 0,0, 2'b00,1,0, 0,0,0));
    tbl.push_back(mkv(2'b00, 0,0, 10,10,10, 0,0, 2'b11,1,0, mk(T_ALU,'h22),mk(T_ALU,'h23),0));
    tbl.push_back(mkv(2'b00, 0,0, 10,10,10, 0,0, 2'b11,1,0, mk(T_ALU,'h24),mk(T_ALU,'h25),0));
    tbl.push_back(mkv(2'b00, 0,0, 10,10,10, 0,0, 2'b11,1,0, mk(T_ALU,'h26),mk(T_ALU,'h27),0));
    tbl.push_back(mkv(2'b00, 0,0, 10,10,10, 0,0, 2'b00,1,0, 0,0,0));
    tbl.push_back(mkv(2'b11, mk(T_ALU,'h30), mk(T_ALU,'h31), 10,10,10, 0,0, 2'b00,1,0, 0,0,0));
    tbl.push_back(mkv(2'b11, mk(T_ALU,'h32), mk(T_ALU,'h33), 10,10,10, 0,1, 2'b00,1,0, 0,0,0));
    tbl.push_back(mkv(2'b01, mk(T_ALU,'h34), 0, 10,10,10, 0,0, 2'b11,1,0, mk(T_ALU,'h30),mk(T_ALU,'h31),0));
    tbl.push_back(mkv(2'b00, 0,0, 10,10,10, 0,0, 2'b11,1,0, mk(T_ALU,'h32),mk(T_ALU,'h33),0));
    tbl.push_back(mkv(2'b00, 0,0, 10,10,10, 0,0, 2'b01,1,0, mk(T_ALU,'h34),0,0));
    tbl.push_back(mkv(2'b00, 0,0, 10,10,10, 0,0, 2'b00,1,0, 0,0,0));

    // Recovery flush with five entries queued, then an extended flush.
    seq_rec.push_back(mkv(2'b11, mk(T_ALU,'h40), mk(T_ALU,'h41), 10,0,10, 0,0, 2'b00,1,0, 0,0,0));
    seq_rec.push_back(mkv(2'b11, mk(T_ALU,'h42), mk(T_ALU,'h43), 10,0,10, 0,0, 2'b00,1,0, 0,0,0));
    seq_rec.push_back(mkv(2'b01, mk(T_ALU,'h44), 0, 10,0,10, 0,0, 2'b00,1,0, 0,0,0));
    seq_rec.push_back(mkv(2'b11, mk(T_ALU,'h45), mk(T_ALU,'h46), 10,10,10, 1,0, 2'b00,0,0, 0,0,0));
    seq_rec.push_back(mkv(2'b11, mk(T_ALU,'h47), mk(T_ALU,'h48), 10,10,10, 0,0, 2'b00,0,0, 0,0,0));
    seq_rec.push_back(mkv(2'b01, mk(T_ALU,'h49), 0, 10,10,10, 0,0, 2'b00,1,0, 0,0,0));
    seq_rec.push_back(mkv(2'b00, 0,0, 10,10,10, 0,0, 2'b01,1,0, mk(T_ALU,'h49),0,0));
    seq_rec.push_back(mkv(2'b00, 0,0, 10,10,10, 1,0, 2'b00,0,0, 0,0,0));
    seq_rec.push_back(mkv(2'b00, 0,0, 10,10,10, 1,0, 2'b00,0,0, 0,0,0));
    seq_rec.push_back(mkv(2'b00, 0,0, 10,10,10, 0,0, 2'b00,0,0, 0,0,0));
    seq_rec.push_back(mkv(2'b00, 0,0, 10,10,10, 0,0, 2'b00,1,0, 0,0,0));

    // Halt in lane 0 ends the group and locks the frontend.
    seq_halt.push_back(mkv(2'b11, mk(T_HALT,'h50), mk(T_ALU,'h51), 10,10,10, 0,0, 2'b00,1,0, 0,0,0));
    seq_halt.push_back(mkv(2'b00, 0,0, 10,10,10, 0,0, 2'b01,1,0, mk(T_HALT,'h50),0,0));
    seq_halt.push_back(mkv(2'b11, mk(T_ALU,'h52), mk(T_ALU,'h53), 10,10,10, 0,0, 2'b00,0,1, 0,0,0));
    seq_halt.push_back(mkv(2'b00, 0,0, 10,10,10, 0,0, 2'b00,0,1, 0,0,0));

    // Halt in the last lane dispatches together with the older lane.
    seq_halt1.push_back(mkv(2'b11, mk(T_ALU,'h60), mk(T_HALT,'h61), 10,10,10, 0,0, 2'b00,1,0, 0,0,0));
    seq_halt1.push_back(mkv(2'b00, 0,0, 10,10,10, 0,0, 2'b11,1,0, mk(T_ALU,'h60),mk(T_HALT,'h61),0));
    seq_halt1.push_back(mkv(2'b00, 0,0, 10,10,10, 0,0, 2'b00,0,1, 0,0,0));

    doReset("reset0");
    for (int r = 0; r < tbl.size(); r++) runRow($sformatf("row%0d", r), tbl[r]);

    doReset("reset1");
    for (int r = 0; r < seq_rec.size(); r++) runRow($sformatf("recover%0d", r), seq_rec[r]);

    doReset("reset2");
    for (int r = 0; r < seq_halt.size(); r++) runRow($sformatf("halt%0d", r), seq_halt[r]);

    doReset("reset3");
    for (int r = 0; r < seq_halt1.size(); r++) runRow($sformatf("haltlast%0d", r), seq_halt1[r]);

    doReset("reset4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
